// File: rtl/sparc_exu_ecl_eccfix_sched.sv
// ECC fix write-back scheduler: queues corrected register values and
// retires them through the IRF write port when normal write-back is idle.
module sparc_exu_ecl_eccfix_sched #(
   parameter int DEPTH      = 4,
   parameter int DATA_W     = 72,
   parameter int STARVE_MAX = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fix_req_m,
   input  logic [4:0]        fix_rd_m,
   input  logic [2:0]        fix_win_m,
   input  logic [DATA_W-1:0] fix_data_m,
   input  logic              wb_port_busy,
   output logic              irf_fix_wen,
   output logic [4:0]        irf_fix_rd,
   output logic [2:0]        irf_fix_win,
   output logic [DATA_W-1:0] irf_fix_data,
   output logic              fix_stall_req,
   output logic              fix_full,
   output logic              fix_busy,
   output logic              fix_ovf
);

   localparam int AW = $clog2(DEPTH);
   localparam int EW = DATA_W + 8;
   localparam logic [7:0] SMAX = 8'(STARVE_MAX);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] DRAIN = 2'd1;
   localparam logic [1:0] STALL = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [AW:0]   head_q, tail_q;
   logic [AW:0]   head_d, tail_d;
   logic [7:0]    cnt_q, cnt_d;
   logic          ovf_q;
   logic [EW-1:0] mem_q [DEPTH];

   logic full, empty, empty_d;
   logic push, pop, drop;

   assign full  = (head_q[AW-1:0] == tail_q[AW-1:0]) &&
                  (head_q[AW] != tail_q[AW]);
   assign empty = (head_q == tail_q);

   assign irf_fix_wen   = (state_q != IDLE) && !wb_port_busy;
   assign fix_stall_req = (state_q == STALL);

   assign pop  = irf_fix_wen;
   // a full queue can still accept when its head leaves this cycle
   assign push = fix_req_m && (!full || pop);
   assign drop = fix_req_m && full && !pop;

   assign head_d  = head_q + {{AW{1'b0}}, pop};
   assign tail_d  = tail_q + {{AW{1'b0}}, push};
   assign empty_d = (head_d == tail_d);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (!empty_d) state_d = DRAIN;
         end
         DRAIN: begin
            if (pop)                cnt_d = 8'd0;
            else if (cnt_q != SMAX) cnt_d = cnt_q + 8'd1;
            if (empty_d)            state_d = IDLE;
            else if (cnt_d == SMAX) state_d = STALL;
         end
         STALL: begin
            if (pop) begin
               cnt_d   = 8'd0;
               state_d = empty_d ? IDLE : DRAIN;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = 8'd0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         head_q  <= '0;
         tail_q  <= '0;
         cnt_q   <= 8'd0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         cnt_q   <= cnt_d;
         ovf_q   <= drop;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (push) begin
         mem_q[tail_q[AW-1:0]] <= {fix_win_m, fix_rd_m, fix_data_m};
      end
   end

   assign {irf_fix_win, irf_fix_rd, irf_fix_data} = mem_q[head_q[AW-1:0]];

   assign fix_full = full;
   assign fix_busy = !empty;
   assign fix_ovf  = ovf_q;

endmodule

// File: tb/tb_sparc_exu_ecl_eccfix_sched.sv
// Randomised scoreboard bench for the ECC fix scheduler against a
// queue-based reference model.
module tb_sparc_exu_ecl_eccfix_sched;

   localparam int DEPTH = 4;
   localparam int DW    = 72;
   localparam int SMAX  = 8;

   logic          clk;
   logic          rst;
   logic          fix_req_m;
   logic [4:0]    fix_rd_m;
   logic [2:0]    fix_win_m;
   logic [DW-1:0] fix_data_m;
   logic          wb_port_busy;
   logic          irf_fix_wen;
   logic [4:0]    irf_fix_rd;
   logic [2:0]    irf_fix_win;
   logic [DW-1:0] irf_fix_data;
   logic          fix_stall_req;
   logic          fix_full;
   logic          fix_busy;
   logic          fix_ovf;

   sparc_exu_ecl_eccfix_sched #(
      .DEPTH(DEPTH), .DATA_W(DW), .STARVE_MAX(SMAX)
   ) dut (
      .clk(clk), .rst(rst),
      .fix_req_m(fix_req_m), .fix_rd_m(fix_rd_m),
      .fix_win_m(fix_win_m), .fix_data_m(fix_data_m),
      .wb_port_busy(wb_port_busy),
      .irf_fix_wen(irf_fix_wen), .irf_fix_rd(irf_fix_rd),
      .irf_fix_win(irf_fix_win), .irf_fix_data(irf_fix_data),
      .fix_stall_req(fix_stall_req), .fix_full(fix_full),
      .fix_busy(fix_busy), .fix_ovf(fix_ovf)
   );

   typedef struct {
      bit wen; bit stall; bit full; bit busy; bit ovf; bit zero;
   } st_t;

   typedef struct {
      logic [4:0] rd; logic [2:0] win; logic [DW-1:0] data;
   } ent_t;

   st_t  stq[$];
   ent_t entq[$];

   int  n_chk  = 0;
   int  n_pass = 0;
   bit  mon_on = 0;
   int  m_occ  = 0;
   int  m_wait = 0;
   bit  m_ovf  = 0;

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   function automatic logic [DW-1:0] rnd_data();
      logic [95:0] w;
      w = {$urandom, $urandom, $urandom};
      return w[DW-1:0];
   endfunction

   // per-cycle stimulus plus reference-model update
   task automatic step(bit req, logic [4:0] rd, logic [2:0] win,
                       logic [DW-1:0] data, bit busy);
      st_t  s;
      ent_t e;
      bit   pop, push;
      @(posedge clk); #1;
      rst          = 0;
      fix_req_m    = req;
      fix_rd_m     = rd;
      fix_win_m    = win;
      fix_data_m   = data;
      wb_port_busy = busy;
      s.wen   = (m_occ > 0) && !busy;
      s.stall = (m_occ > 0) && (m_wait >= SMAX);
      s.full  = (m_occ == DEPTH);
      s.busy  = (m_occ > 0);
      s.ovf   = m_ovf;
      s.zero  = 0;
      stq.push_back(s);
      pop  = s.wen;
      push = req && (m_occ < DEPTH || pop);
      if (push) begin
         e.rd = rd; e.win = win; e.data = data;
         entq.push_back(e);
      end
      if (pop) m_wait = 0;
      else if (m_occ > 0 && busy && m_wait < SMAX) m_wait++;
      m_occ = m_occ + int'(push) - int'(pop);
      m_ovf = req && !push;
   endtask

   task automatic rstep(bit busy);
      step(1'b1, 5'($urandom), 3'($urandom), rnd_data(), busy);
   endtask

   task automatic idle(bit busy);
      step(1'b0, 5'd0, 3'd0, '0, busy);
   endtask

   task automatic do_reset();
      st_t s;
      @(posedge clk); #1;
      rst       = 1;
      fix_req_m = 0;
      mon_on    = 1;
      m_occ = 0; m_wait = 0; m_ovf = 0;
      entq.delete();
      s = '{0, 0, 0, 0, 0, 1};
      stq.push_back(s);
   endtask

   // monitor: compares DUT against the expectations queued by the driver
   initial begin
      st_t  s;
      ent_t e;
      forever begin
         @(negedge clk);
         if (mon_on) begin
            if (stq.size() == 0) begin
               chk("status_queue_empty", 1, 0);
            end else begin
               s = stq.pop_front();
               chk("wen",   DW'(irf_fix_wen),   DW'(s.wen));
               chk("stall", DW'(fix_stall_req), DW'(s.stall));
               chk("full",  DW'(fix_full),      DW'(s.full));
               chk("busy",  DW'(fix_busy),      DW'(s.busy));
               chk("ovf",   DW'(fix_ovf),       DW'(s.ovf));
               if (s.zero) begin
                  chk("rst_data", irf_fix_data, '0);
                  chk("rst_rd",   DW'(irf_fix_rd),  '0);
                  chk("rst_win",  DW'(irf_fix_win), '0);
               end
            end
            if (irf_fix_wen === 1'b1) begin
               if (entq.size() == 0) begin
                  chk("unexpected_write", 1, 0);
               end else begin
                  e = entq.pop_front();
                  chk("wr_rd",   DW'(irf_fix_rd),  DW'(e.rd));
                  chk("wr_win",  DW'(irf_fix_win), DW'(e.win));
                  chk("wr_data", irf_fix_data,     e.data);
               end
            end
         end
      end
   end

   initial begin
      int pct;
      rst          = 1;
      fix_req_m    = 0;
      fix_rd_m     = 0;
      fix_win_m    = 0;
      fix_data_m   = '0;
      wb_port_busy = 0;
      do_reset();
      idle(0);

      // single fix, port free
      step(1, 5'd5, 3'd3, 72'hA5, 0);
      idle(0); idle(0); idle(0);

      // port contention
      step(1, 5'd7, 3'd1, 72'h111, 1);
      step(1, 5'd8, 3'd2, 72'h222, 1);
      idle(1);
      repeat (3) idle(0);

      // starvation
      step(1, 5'd9, 3'd4, 72'h333, 1);
      repeat (10) idle(1);
      repeat (3) idle(0);

      // overflow
      repeat (5) rstep(1);
      idle(1); idle(1);
      // full with simultaneous push and pop
      rstep(0); rstep(0);
      repeat (6) idle(0);

      // %g0 target
      step(1, 5'd0, 3'd0, 72'hDEAD, 0);
      idle(0); idle(0);

      // reset mid-drain
      repeat (3) rstep(1);
      do_reset();
      idle(0);
      step(1, 5'd17, 3'd6, 72'hCAFE, 0);
      idle(0); idle(0);

      // random traffic with varying port pressure
      for (int blk = 0; blk < 12; blk++) begin
         pct = (blk % 3 == 0) ? 10 : (blk % 3 == 1) ? 50 : 95;
         for (int i = 0; i < 150; i++) begin
            if ($urandom_range(99) < 55) rstep($urandom_range(99) < pct);
            else idle($urandom_range(99) < pct);
         end
      end

      repeat (DEPTH + 4) idle(0);
      @(negedge clk); #1;
      mon_on = 0;
      chk("entries_left", DW'(entq.size()), '0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
